// File: rtl/softmax_pkg_16.sv
// Shared constants for the 16-bit softmax pipeline: FP32 field layout,
// fixed-point format and the upscale stage state encoding.
package softmax_pkg_16;

   localparam int unsigned FP32_BIAS     = 127;
   localparam int unsigned FXP_FRAC_BITS = 8;
   localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;

   localparam int unsigned FP32_SIGN_W = 1;
   localparam int unsigned FP32_EXP_W  = 8;
   localparam int unsigned FP32_MANT_W = 23;

   typedef enum logic {
      COLLECT = 1'b0,
      SEND    = 1'b1
   } state_e;

endpackage

// File: rtl/fxp16_to_fp32.sv
// Exact combinational conversion of a signed 16-bit fixed-point value to FP32:
// leading-one detect on the magnitude, normalise, then pack the fields.
module fxp16_to_fp32
   import softmax_pkg_16::*;
#(
   parameter int unsigned frac_bits = FXP_FRAC_BITS
) (
   input  logic [15:0] fxp_i,
   output logic [31:0] fp_o
);

   logic                   sign;
   logic [15:0]            mag;
   logic [15:0]            mag_clr;
   logic [3:0]             lead;
   logic [FP32_EXP_W-1:0]  exp_v;
   logic [FP32_MANT_W-1:0] mant;

   always_comb begin
      sign = fxp_i[15];
      // 0x8000 negates to itself, which is the correct unsigned magnitude.
      mag  = sign ? (~fxp_i + 16'd1) : fxp_i;
      lead = '0;
      for (int i = 0; i < 16; i++) begin
         if (mag[i]) lead = 4'(i);
      end
      mag_clr       = mag;
      mag_clr[lead] = 1'b0;
      exp_v = FP32_EXP_W'(FP32_BIAS + 32'(lead) - frac_bits);
      mant  = FP32_MANT_W'(mag_clr) << (5'd23 - 5'(lead));
      fp_o  = (mag == '0) ? FP32_ZERO : {sign, exp_v, mant};
   end

endmodule

// File: rtl/upscale_block_16.sv
// Collects a frame of Q1.7.8 results, then streams them out as FP32 in arrival
// order under valid/ready backpressure. Input words arriving during SEND are dropped.
module upscale_block_16
   import softmax_pkg_16::*;
#(
   parameter int unsigned data_size      = 16,
   parameter int unsigned frac_bits      = FXP_FRAC_BITS,
   parameter int unsigned number_of_data = 10
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 upscale_data_valid_i,
   input  logic [data_size-1:0] upscale_data_i,
   input  logic                 upscale_ready_i,
   output logic                 upscale_data_valid_o,
   output logic [31:0]          upscale_data_o,
   output logic                 upscale_last_o,
   output logic                 upscale_busy_o
);

   localparam int unsigned CntW = $clog2(number_of_data + 1);
   localparam int unsigned IdxW = $clog2(number_of_data);

   state_e                state_q, state_d;
   logic [CntW-1:0]       wr_cnt_q, wr_cnt_d;
   logic [CntW-1:0]       rd_cnt_q, rd_cnt_d;
   logic [data_size-1:0]  frame_q [number_of_data];
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [31:0]           data_q, data_d;

   logic                  accept;
   logic                  wr_last;
   logic                  load;
   logic                  hs;
   logic [31:0]           conv_data;

   assign accept  = (state_q == COLLECT) && upscale_data_valid_i;
   assign wr_last = (wr_cnt_q == CntW'(number_of_data - 1));
   assign hs      = valid_q && upscale_ready_i;
   assign load    = (state_q == SEND) && (!valid_q || upscale_ready_i) &&
                    (rd_cnt_q < CntW'(number_of_data));

   fxp16_to_fp32 #(
      .frac_bits (frac_bits)
   ) u_conv (
      .fxp_i (frame_q[IdxW'(rd_cnt_q)]),
      .fp_o  (conv_data)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= COLLECT;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      unique case (state_q)
         COLLECT: begin
            if (accept) begin
               wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
               if (wr_last) begin
                  state_d  = SEND;
                  rd_cnt_d = '0;
               end
            end
         end
         SEND: begin
            if (load) rd_cnt_d = rd_cnt_q + 1'b1;
            if (hs && last_q) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      if (load) begin
         data_d  = conv_data;
         valid_d = 1'b1;
         last_d  = (rd_cnt_q == CntW'(number_of_data - 1));
      end else if (hs) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= FP32_ZERO;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < int'(number_of_data); i++) frame_q[i] <= '0;
      end else if (accept) begin
         frame_q[IdxW'(wr_cnt_q)] <= upscale_data_i;
      end
   end

   assign upscale_data_valid_o = valid_q;
   assign upscale_data_o       = data_q;
   assign upscale_last_o       = last_q;
   assign upscale_busy_o       = (state_q == SEND);

endmodule
